// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding and frame defaults.
// Also used by the master-side testbench model.
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 8;
  localparam logic [7:0]  SPI_IDLE_FILL  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous input.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronised out).
// RST_VAL is the idle level of the input so reset produces no false edge.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by clk (SCLK <= clk/8).
// Ports: clk/reset (sync, active-high); spi_sclk/spi_ss_n/spi_mosi async
// SPI inputs; spi_miso/spi_miso_oe serial output and enable; tx_data/
// tx_valid/tx_ready one-entry tx queue; rx_data/rx_valid received frames;
// busy = slave selected; tx_underrun = frame started with nothing queued.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = SPI_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]  IDLE_FILL  = DATA_WIDTH'(SPI_IDLE_FILL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_ss_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s, ss_n_s, mosi_s;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(spi_sclk), .q(sclk_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_ss_n (.clk(clk), .reset(reset), .d(spi_ss_n), .q(ss_n_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_s));

  state_e                state_q, state_d;
  logic                  sclk_prev_q, sclk_prev_d;
  logic                  ss_n_prev_q, ss_n_prev_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] shift_out_q, shift_out_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  underrun_pend_q, underrun_pend_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_underrun_q, tx_underrun_d;
  logic                  busy_q, busy_d;
  logic                  miso_oe_q, miso_oe_d;
  logic                  tx_ready_q, tx_ready_d;

  logic                  sclk_rise_c, sclk_fall_c, ss_fall_c, tx_accept_c, load_c;
  logic [DATA_WIDTH-1:0] rx_word_c;

  assign sclk_rise_c = sclk_s & ~sclk_prev_q;
  assign sclk_fall_c = ~sclk_s & sclk_prev_q;
  assign ss_fall_c   = ~ss_n_s & ss_n_prev_q;
  assign tx_accept_c = tx_valid & tx_ready_q;

  // Next-state: frame sequencing, shift paths and tx holding register.
  always_comb begin
    state_d         = state_q;
    sclk_prev_d     = sclk_s;
    ss_n_prev_d     = ss_n_s;
    cnt_d           = cnt_q;
    rx_shift_d      = rx_shift_q;
    shift_out_d     = shift_out_q;
    hold_d          = hold_q;
    hold_valid_d    = hold_valid_q;
    frame_done_d    = frame_done_q;
    underrun_pend_d = underrun_pend_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    tx_underrun_d   = 1'b0;
    busy_d          = ~ss_n_s;
    load_c          = 1'b0;
    rx_word_c       = {rx_shift_q, mosi_s};

    if (ss_n_s) begin
      // Deselected: abandon any partial frame, keep the holding register.
      state_d         = ST_IDLE;
      cnt_d           = '0;
      rx_shift_d      = '0;
      shift_out_d     = '0;
      frame_done_d    = 1'b0;
      underrun_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_fall_c) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          state_d       = ST_SHIFT;
          load_c        = 1'b1;
          tx_underrun_d = ~hold_valid_q & ~tx_accept_c;
        end
        ST_SHIFT: begin
          if (sclk_rise_c) begin
            rx_shift_d = rx_word_c[DATA_WIDTH-2:0];
            // Underrun of a back-to-back reload is reported only once the
            // master actually clocks the next frame.
            if (underrun_pend_q) begin
              tx_underrun_d   = 1'b1;
              underrun_pend_d = 1'b0;
            end
            if (cnt_q == LAST_BIT) begin
              cnt_d        = '0;
              rx_data_d    = rx_word_c;
              rx_valid_d   = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall_c) begin
            if (frame_done_q) begin
              load_c          = 1'b1;
              frame_done_d    = 1'b0;
              underrun_pend_d = ~hold_valid_q & ~tx_accept_c;
            end else begin
              shift_out_d = {shift_out_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A handshake coinciding with a load goes straight to the shifter.
    if (load_c) begin
      if (hold_valid_q) begin
        shift_out_d  = hold_q;
        hold_valid_d = 1'b0;
      end else if (tx_accept_c) begin
        shift_out_d = tx_data;
      end else begin
        shift_out_d = IDLE_FILL;
      end
    end else if (tx_accept_c) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    tx_ready_d = ~hold_valid_d;
    miso_oe_d  = (state_d != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      sclk_prev_q     <= 1'b0;
      ss_n_prev_q     <= 1'b1;
      cnt_q           <= '0;
      rx_shift_q      <= '0;
      shift_out_q     <= '0;
      hold_q          <= '0;
      hold_valid_q    <= 1'b0;
      frame_done_q    <= 1'b0;
      underrun_pend_q <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      tx_underrun_q   <= 1'b0;
      busy_q          <= 1'b0;
      miso_oe_q       <= 1'b0;
      tx_ready_q      <= 1'b1;
    end else begin
      state_q         <= state_d;
      sclk_prev_q     <= sclk_prev_d;
      ss_n_prev_q     <= ss_n_prev_d;
      cnt_q           <= cnt_d;
      rx_shift_q      <= rx_shift_d;
      shift_out_q     <= shift_out_d;
      hold_q          <= hold_d;
      hold_valid_q    <= hold_valid_d;
      frame_done_q    <= frame_done_d;
      underrun_pend_q <= underrun_pend_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      tx_underrun_q   <= tx_underrun_d;
      busy_q          <= busy_d;
      miso_oe_q       <= miso_oe_d;
      tx_ready_q      <= tx_ready_d;
    end
  end

  assign spi_miso    = shift_out_q[DATA_WIDTH-1];
  assign spi_miso_oe = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign tx_underrun = tx_underrun_q;

endmodule
